// File: rtl/counter_sequence_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_sequence_monitor: checks a 4-bit up count for +1 mod 16 steps,   |
// | reporting lock, wrap and sequence-error status with saturating tallies.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module counter_sequence_monitor #(
   parameter int LOCK_COUNT = 2,
   parameter int WRAP_W     = 8,
   parameter int ERR_W      = 4,
   parameter int ALLOW_HOLD = 0
) (
   input  logic              Clk,
   input  logic              rst,
   input  logic              Q0,
   input  logic              Q1,
   input  logic              Q2,
   input  logic              Q3,
   output logic [3:0]        count_val,
   output logic              locked,
   output logic              tc_pulse,
   output logic              err_pulse,
   output logic              fault_sticky,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic [ERR_W-1:0]  err_cnt
);

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_LOCKING = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_FAULT   = 2'd3
   } state_t;

   localparam logic [3:0] C_LOCK_COUNT = 4'(LOCK_COUNT);
   localparam bit         C_ALLOW_HOLD = (ALLOW_HOLD != 0);

   state_t            state_q, state_d;
   logic [3:0]        streak_q, streak_d;
   logic [3:0]        samp_q, samp_d;
   logic [3:0]        last_q, last_d;
   logic              vld_q, vld_d;
   logic              locked_q, locked_d;
   logic              tc_q, tc_d;
   logic              err_q, err_d;
   logic              fault_q, fault_d;
   logic [WRAP_W-1:0] wrap_q, wrap_d;
   logic [ERR_W-1:0]  errc_q, errc_d;

   logic [3:0]        w_delta;
   logic              w_is_inc;
   logic              w_is_hold;
   logic              w_legal;

   always_comb begin
      w_delta   = samp_q - last_q;
      w_is_inc  = (w_delta == 4'd1);
      w_is_hold = C_ALLOW_HOLD && (w_delta == 4'd0);
      w_legal   = w_is_inc || w_is_hold;

      state_d   = state_q;
      streak_d  = streak_q;
      samp_d    = {Q3, Q2, Q1, Q0};
      last_d    = samp_q;
      vld_d     = 1'b1;
      tc_d      = 1'b0;
      err_d     = 1'b0;
      fault_d   = fault_q;
      wrap_d    = wrap_q;
      errc_d    = errc_q;

      case (state_q)
         // samp holds reset junk until the first real sample has been taken
         ST_ACQUIRE: begin
            if (vld_q) begin
               state_d  = ST_LOCKING;
               streak_d = 4'd0;
            end
         end
         ST_LOCKING: begin
            if (w_is_inc) begin
               if (streak_q + 4'd1 == C_LOCK_COUNT) begin
                  state_d  = ST_LOCKED;
                  streak_d = 4'd0;
               end else begin
                  streak_d = streak_q + 4'd1;
               end
            end else if (!w_is_hold) begin
               streak_d = 4'd0;
            end
         end
         ST_LOCKED: begin
            if (w_legal) begin
               if (last_q == 4'd15 && samp_q == 4'd0) begin
                  tc_d = 1'b1;
                  if (wrap_q != {WRAP_W{1'b1}}) wrap_d = wrap_q + WRAP_W'(1);
               end
            end else begin
               err_d   = 1'b1;
               fault_d = 1'b1;
               state_d = ST_FAULT;
               if (errc_q != {ERR_W{1'b1}}) errc_d = errc_q + ERR_W'(1);
            end
         end
         ST_FAULT: begin
            state_d  = ST_LOCKING;
            streak_d = 4'd0;
         end
         default: begin
            state_d  = ST_ACQUIRE;
            streak_d = 4'd0;
         end
      endcase

      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge Clk) begin
      if (rst) begin
         state_q  <= ST_ACQUIRE;
         streak_q <= 4'd0;
         samp_q   <= 4'd0;
         last_q   <= 4'd0;
         vld_q    <= 1'b0;
         locked_q <= 1'b0;
         tc_q     <= 1'b0;
         err_q    <= 1'b0;
         fault_q  <= 1'b0;
         wrap_q   <= '0;
         errc_q   <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         samp_q   <= samp_d;
         last_q   <= last_d;
         vld_q    <= vld_d;
         locked_q <= locked_d;
         tc_q     <= tc_d;
         err_q    <= err_d;
         fault_q  <= fault_d;
         wrap_q   <= wrap_d;
         errc_q   <= errc_d;
      end
   end

   assign count_val    = samp_q;
   assign locked       = locked_q;
   assign tc_pulse     = tc_q;
   assign err_pulse    = err_q;
   assign fault_sticky = fault_q;
   assign wrap_cnt     = wrap_q;
   assign err_cnt      = errc_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequence_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_counter_sequence_monitor: directed self-checking bench.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_counter_sequence_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       q0 = 1'b0, q1 = 1'b0, q2 = 1'b0, q3 = 1'b0;

   logic [3:0] cv, cv_h;
   logic       lk, lk_h, tc, tc_h, er, er_h, fs, fs_h;
   logic [7:0] wc, wc_h;
   logic [3:0] ec, ec_h;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   counter_sequence_monitor #(.LOCK_COUNT(2), .WRAP_W(8), .ERR_W(4), .ALLOW_HOLD(0)) dut (
      .Clk(clk), .rst(rst), .Q0(q0), .Q1(q1), .Q2(q2), .Q3(q3),
      .count_val(cv), .locked(lk), .tc_pulse(tc), .err_pulse(er),
      .fault_sticky(fs), .wrap_cnt(wc), .err_cnt(ec)
   );

   counter_sequence_monitor #(.LOCK_COUNT(2), .WRAP_W(8), .ERR_W(4), .ALLOW_HOLD(1)) dut_h (
      .Clk(clk), .rst(rst), .Q0(q0), .Q1(q1), .Q2(q2), .Q3(q3),
      .count_val(cv_h), .locked(lk_h), .tc_pulse(tc_h), .err_pulse(er_h),
      .fault_sticky(fs_h), .wrap_cnt(wc_h), .err_cnt(ec_h)
   );

   task automatic step(input logic [3:0] v);
      {q3, q2, q1, q0} = v;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(4'd0);
      step(4'd0);
      checks++;
      if ({cv, lk, tc, er, fs, wc, ec} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h exp 0", {cv, lk, tc, er, fs, wc, ec});
      end
      rst = 1'b0;
   endtask

   task automatic test_free_run();
      for (int i = 0; i < 128; i++) begin
         logic e_lk, e_tc;
         step(4'(i));
         e_lk = (i >= 3);
         e_tc = (i >= 17) && (i % 16 == 1);
         checks += 4;
         if (cv !== 4'(i)) begin errors++; $display("FAIL run_count_val i=%0d got %0d exp %0d", i, cv, 4'(i)); end
         if (lk !== e_lk)  begin errors++; $display("FAIL run_locked i=%0d got %0d exp %0d", i, lk, e_lk); end
         if (tc !== e_tc)  begin errors++; $display("FAIL run_tc i=%0d got %0d exp %0d", i, tc, e_tc); end
         if (er !== 1'b0)  begin errors++; $display("FAIL run_err i=%0d got %0d exp 0", i, er); end
         if (i == 63) begin
            checks++;
            if (wc !== 8'd3) begin errors++; $display("FAIL run_wrap3 got %0d exp 3", wc); end
         end
      end
      checks++;
      if (wc !== 8'd7) begin errors++; $display("FAIL run_wrap7 got %0d exp 7", wc); end
   endtask

   task automatic test_reset_locked();
      checks++;
      if (lk !== 1'b1) begin errors++; $display("FAIL pre_rst_locked got %0d exp 1", lk); end
      rst = 1'b1;
      step(4'd5);
      rst = 1'b0;
      checks += 2;
      if ({cv, lk, tc, er, fs, wc, ec} !== 19'd0) begin
         errors++;
         $display("FAIL rst_locked_outputs got %h exp 0", {cv, lk, tc, er, fs, wc, ec});
      end
      if (wc_h !== 8'd0) begin errors++; $display("FAIL rst_hold_wrap got %0d exp 0", wc_h); end
   endtask

   task automatic test_locking();
      logic [3:0] seq [4] = '{4'd2, 4'd3, 4'd8, 4'd9};
      foreach (seq[j]) begin
         step(seq[j]);
         checks += 2;
         if (lk !== 1'b0) begin errors++; $display("FAIL locking_early j=%0d got %0d exp 0", j, lk); end
         if (er !== 1'b0) begin errors++; $display("FAIL locking_err j=%0d got %0d exp 0", j, er); end
      end
      step(4'd10);
      checks += 2;
      if (lk !== 1'b0) begin errors++; $display("FAIL locking_s10 got %0d exp 0", lk); end
      if (ec !== 4'd0) begin errors++; $display("FAIL locking_errcnt got %0d exp 0", ec); end
      step(4'd11);
      checks++;
      if (lk !== 1'b1) begin errors++; $display("FAIL locking_rise got %0d exp 1", lk); end
   endtask

   task automatic test_error();
      logic [3:0] pre [12] = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1,
                               4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
      foreach (pre[j]) step(pre[j]);
      step(4'd9);
      checks += 3;
      if (lk !== 1'b1) begin errors++; $display("FAIL err_pre_locked got %0d exp 1", lk); end
      if (er !== 1'b0) begin errors++; $display("FAIL err_pre_pulse got %0d exp 0", er); end
      if (wc !== 8'd1) begin errors++; $display("FAIL err_pre_wrap got %0d exp 1", wc); end
      step(4'd10);
      checks += 5;
      if (er !== 1'b1) begin errors++; $display("FAIL err_pulse got %0d exp 1", er); end
      if (ec !== 4'd1) begin errors++; $display("FAIL err_cnt got %0d exp 1", ec); end
      if (fs !== 1'b1) begin errors++; $display("FAIL err_fault got %0d exp 1", fs); end
      if (lk !== 1'b0) begin errors++; $display("FAIL err_locked got %0d exp 0", lk); end
      if (tc !== 1'b0) begin errors++; $display("FAIL err_tc got %0d exp 0", tc); end
      step(4'd11);
      checks += 2;
      if (er !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %0d exp 0", er); end
      if (lk !== 1'b0) begin errors++; $display("FAIL err_fault_locked got %0d exp 0", lk); end
      step(4'd12);
      step(4'd13);
      checks += 2;
      if (lk !== 1'b1) begin errors++; $display("FAIL err_relock got %0d exp 1", lk); end
      if (fs !== 1'b1) begin errors++; $display("FAIL err_sticky got %0d exp 1", fs); end
   endtask

   task automatic test_hold();
      logic [3:0] seq [9] = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5};
      foreach (seq[j]) step(seq[j]);
      checks += 2;
      if (lk !== 1'b1) begin errors++; $display("FAIL hold_pre_locked got %0d exp 1", lk); end
      if (er !== 1'b0) begin errors++; $display("FAIL hold_pre_err got %0d exp 0", er); end
      step(4'd6);
      checks += 7;
      if (er !== 1'b1)   begin errors++; $display("FAIL hold0_err got %0d exp 1", er); end
      if (ec !== 4'd2)   begin errors++; $display("FAIL hold0_errcnt got %0d exp 2", ec); end
      if (lk !== 1'b0)   begin errors++; $display("FAIL hold0_locked got %0d exp 0", lk); end
      if (wc !== 8'd2)   begin errors++; $display("FAIL hold0_wrap got %0d exp 2", wc); end
      if (er_h !== 1'b0) begin errors++; $display("FAIL hold1_err got %0d exp 0", er_h); end
      if (lk_h !== 1'b1) begin errors++; $display("FAIL hold1_locked got %0d exp 1", lk_h); end
      if (ec_h !== 4'd1) begin errors++; $display("FAIL hold1_errcnt got %0d exp 1", ec_h); end
   endtask

   task automatic test_err_saturate();
      logic [3:0] y = 4'd6;
      for (int n = 1; n <= 15; n++) begin
         logic [3:0] e_ec;
         step(y + 4'd1);
         step(y + 4'd2);
         step(y + 4'd3);
         checks++;
         if (lk !== 1'b1) begin errors++; $display("FAIL sat_relock n=%0d got %0d exp 1", n, lk); end
         step(y + 4'd6);
         step(y + 4'd7);
         e_ec = (n + 2 > 15) ? 4'd15 : 4'(n + 2);
         checks += 3;
         if (er !== 1'b1) begin errors++; $display("FAIL sat_pulse n=%0d got %0d exp 1", n, er); end
         if (ec !== e_ec) begin errors++; $display("FAIL sat_errcnt n=%0d got %0d exp %0d", n, ec, e_ec); end
         if (lk !== 1'b0) begin errors++; $display("FAIL sat_locked n=%0d got %0d exp 0", n, lk); end
         y = y + 4'd7;
      end
      checks++;
      if (ec !== 4'd15) begin errors++; $display("FAIL sat_final got %0d exp 15", ec); end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_reset_locked();
      test_locking();
      test_error();
      test_hold();
      test_err_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
